reorder_bank_scheduler: RTL and testbench

- Sequencing controller for the two-bank line reorder datapath (two line-reorder buffers behind an AXI-Stream demux/mux pair).
- Takes a per-frame configuration: line length and lines per frame.
- Tracks the fill/drain state of each bank and steers writes and reads between them.
- Generates line-boundary (last) markers on both sides and signals frame completion.
- Replaces the free-running bank toggle with explicit, configurable, abortable frame scheduling.

---
 rtl/reorder_pkg.sv | 42 ++++
 rtl/reorder_bank_tracker.sv | 54 +++++
 rtl/reorder_bank_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_reorder_bank_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_pkg
//  Purpose  : Shared types and width helpers for the two-bank line reorder
//             scheduler and its per-bank tracker.
//  Contents : bank_state_t, top_state_t, width helper functions and the
//             default-parameter width constants LenW / LinesW.
//  Revision : 1.0 - initial release
// ============================================================================
package reorder_pkg;

  // Per-bank occupancy: written (FILL), ready to read (FULL), being read (DRAIN).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } bank_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } top_state_t;

  localparam int unsigned DefMaxLineSize = 512;
  localparam int unsigned DefMaxLines    = 4096;

  // Width of a field that must hold 0..max inclusive.
  function automatic int unsigned len_w(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  // Width of a beat counter that only ever holds 0..max-1; never below 1 bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  localparam int unsigned LenW   = len_w(DefMaxLineSize);
  localparam int unsigned LinesW = len_w(DefMaxLines);

endpackage : reorder_pkg
`default_nettype wire

// File: rtl/reorder_bank_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_bank_tracker
//  Purpose  : Occupancy state of one line-reorder bank:
//             EMPTY -> FILL -> FULL -> DRAIN -> EMPTY.
//  Ports    : clk_i, rst_i    - clock, synchronous active-high reset
//             clear_i         - force EMPTY (frame abort)
//             wr_hit_i        - a write beat lands in this bank this cycle
//             wr_last_i       - that write beat closes the line
//             rd_hit_i        - a read beat leaves this bank this cycle
//             rd_last_i       - that read beat closes the line
//             state_o         - registered bank state
//  Revision : 1.0 - initial release
// ============================================================================
module reorder_bank_tracker
  import reorder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        wr_hit_i,
  input  logic        wr_last_i,
  input  logic        rd_hit_i,
  input  logic        rd_last_i,
  output bank_state_t state_o
);

  bank_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      // A one-beat line goes straight to FULL.
      EMPTY:   if (wr_hit_i) state_d = wr_last_i ? FULL : FILL;
      FILL:    if (wr_hit_i && wr_last_i) state_d = FULL;
      FULL:    if (rd_hit_i) state_d = rd_last_i ? EMPTY : DRAIN;
      DRAIN:   if (rd_hit_i && rd_last_i) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (clear_i) state_d = EMPTY;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule : reorder_bank_tracker
`default_nettype wire

// File: rtl/reorder_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_bank_scheduler
//  Purpose  : Frame sequencer for the two-bank line reorder datapath. Latches
//             a per-frame config, steers writes/reads between the banks,
//             generates line-last markers and signals frame completion.
//  Ports    : clk_i, rst_i                    - clock, sync active-high reset
//             cfg_line_len_i, cfg_num_lines_i - frame config, sampled on start
//             start_i, abort_i                - frame control
//             busy_o, cfg_err_o               - status (cfg_err_o is a pulse)
//             wr_bank_o, wr_en_o, wr_fire_i, wr_last_o - input side
//             rd_bank_o, rd_en_o, rd_fire_i, rd_last_o - output side
//             frame_done_o                    - pulse after final line read
//  Revision : 1.0 - initial release
// ============================================================================
module reorder_bank_scheduler
  import reorder_pkg::*;
#(
  parameter int unsigned MaxLineSize = 512,
  parameter int unsigned MaxLines    = 4096,
  parameter bit          DoubleBuff  = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [$clog2(MaxLineSize+1)-1:0] cfg_line_len_i,
  input  logic [$clog2(MaxLines+1)-1:0]    cfg_num_lines_i,
  input  logic                             start_i,
  input  logic                             abort_i,
  output logic                             busy_o,
  output logic                             cfg_err_o,
  output logic                             wr_bank_o,
  output logic                             wr_en_o,
  input  logic                             wr_fire_i,
  output logic                             wr_last_o,
  output logic                             rd_bank_o,
  output logic                             rd_en_o,
  input  logic                             rd_fire_i,
  output logic                             rd_last_o,
  output logic                             frame_done_o
);

  localparam int unsigned LenBits   = len_w(MaxLineSize);
  localparam int unsigned LinesBits = len_w(MaxLines);
  localparam int unsigned CntBits   = cnt_w(MaxLineSize);

  localparam logic [LenBits-1:0]   MaxLenVal   = LenBits'(MaxLineSize);
  localparam logic [LinesBits-1:0] MaxLinesVal = LinesBits'(MaxLines);

  top_state_t             state_q, state_d;
  logic [LenBits-1:0]     len_q, len_d;
  logic [LinesBits-1:0]   lines_q, lines_d;
  logic [CntBits-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CntBits-1:0]     rd_cnt_q, rd_cnt_d;
  logic [LinesBits-1:0]   wr_lines_q, wr_lines_d;
  logic [LinesBits-1:0]   rd_lines_q, rd_lines_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   frame_done_q, frame_done_d;

  bank_state_t            bank_state [2];

  logic                   run;
  logic                   wr_en, rd_en;
  logic                   wr_last, rd_last;
  logic                   wr_go, rd_go;
  logic                   abort_hit;
  logic                   frame_end;
  logic                   cfg_bad;
  logic [LenBits-1:0]     len_m1;

  // --------------------------------------------------------------------------
  // Enables and last markers depend only on registered state, so there is no
  // combinational path from a fire input to any enable.
  // --------------------------------------------------------------------------
  always_comb begin
    run     = (state_q == RUN);
    len_m1  = len_q - LenBits'(1);
    wr_en   = run && (wr_lines_q < lines_q) &&
              ((bank_state[wr_bank_q] == EMPTY) || (bank_state[wr_bank_q] == FILL));
    rd_en   = run &&
              ((bank_state[rd_bank_q] == FULL) || (bank_state[rd_bank_q] == DRAIN));
    wr_last = wr_en && (LenBits'(wr_cnt_q) == len_m1);
    rd_last = rd_en && (LenBits'(rd_cnt_q) == len_m1);

    // Abort wins over any same-cycle beat.
    abort_hit = run && abort_i;
    wr_go     = wr_en && wr_fire_i && !abort_i;
    rd_go     = rd_en && rd_fire_i && !abort_i;
    frame_end = rd_go && rd_last && (rd_lines_q == (lines_q - LinesBits'(1)));

    cfg_bad = (cfg_line_len_i == '0) || (cfg_line_len_i > MaxLenVal) ||
              (cfg_num_lines_i == '0) || (cfg_num_lines_i > MaxLinesVal);
  end

  // --------------------------------------------------------------------------
  // Top FSM, counters and bank pointers
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    lines_d      = lines_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    wr_lines_d   = wr_lines_q;
    rd_lines_d   = rd_lines_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    cfg_err_d    = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d   = cfg_line_len_i;
          lines_d = cfg_num_lines_i;
          if (cfg_bad) cfg_err_d = 1'b1;
          else         state_d   = RUN;
        end
      end

      RUN: begin
        if (wr_go) begin
          if (wr_last) begin
            wr_cnt_d   = '0;
            wr_lines_d = wr_lines_q + LinesBits'(1);
            if (DoubleBuff) wr_bank_d = ~wr_bank_q;
          end else begin
            wr_cnt_d = wr_cnt_q + CntBits'(1);
          end
        end

        if (rd_go) begin
          if (rd_last) begin
            rd_cnt_d   = '0;
            rd_lines_d = rd_lines_q + LinesBits'(1);
            if (DoubleBuff) rd_bank_d = ~rd_bank_q;
          end else begin
            rd_cnt_d = rd_cnt_q + CntBits'(1);
          end
        end

        if (frame_end) frame_done_d = 1'b1;

        // Leaving RUN either way: the next frame starts from bank 0 with
        // fresh counters.
        if (abort_hit || frame_end) begin
          state_d    = IDLE;
          wr_cnt_d   = '0;
          rd_cnt_d   = '0;
          wr_lines_d = '0;
          rd_lines_d = '0;
          wr_bank_d  = 1'b0;
          rd_bank_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      lines_q      <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wr_lines_q   <= '0;
      rd_lines_q   <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      lines_q      <= lines_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_lines_q   <= wr_lines_d;
      rd_lines_q   <= rd_lines_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      cfg_err_q    <= cfg_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-bank occupancy trackers. With DoubleBuff = 0 the pointers never leave
  // bank 0, so bank 1 simply stays EMPTY.
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank_tracker u_tracker (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (abort_hit),
      .wr_hit_i  (wr_go && (wr_bank_q == 1'(b))),
      .wr_last_i (wr_last),
      .rd_hit_i  (rd_go && (rd_bank_q == 1'(b))),
      .rd_last_i (rd_last),
      .state_o   (bank_state[b])
    );
  end

  assign busy_o       = run;
  assign cfg_err_o    = cfg_err_q;
  assign wr_bank_o    = wr_bank_q;
  assign wr_en_o      = wr_en;
  assign wr_last_o    = wr_last;
  assign rd_bank_o    = rd_bank_q;
  assign rd_en_o      = rd_en;
  assign rd_last_o    = rd_last;
  assign frame_done_o = frame_done_q;

endmodule : reorder_bank_scheduler
`default_nettype wire

// File: tb/tb_reorder_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reorder_bank_scheduler
//  Purpose  : Self-checking bench for reorder_bank_scheduler. Instance dut_a
//             is double-buffered, dut_b is single-bank; both share inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_bank_scheduler;

  localparam int LW = 10;
  localparam int NW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] cfg_len;
  logic [NW-1:0] cfg_lines;
  logic          start, abort, wr_fire, rd_fire;

  logic busy_a, err_a, wr_bank_a, wr_en_a, wr_last_a, rd_bank_a, rd_en_a, rd_last_a, done_a;
  logic busy_b, err_b, wr_bank_b, wr_en_b, wr_last_b, rd_bank_b, rd_en_b, rd_last_b, done_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reorder_bank_scheduler #(.MaxLineSize(512), .MaxLines(4096), .DoubleBuff(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .cfg_line_len_i(cfg_len), .cfg_num_lines_i(cfg_lines),
    .start_i(start), .abort_i(abort), .busy_o(busy_a), .cfg_err_o(err_a),
    .wr_bank_o(wr_bank_a), .wr_en_o(wr_en_a), .wr_fire_i(wr_fire), .wr_last_o(wr_last_a),
    .rd_bank_o(rd_bank_a), .rd_en_o(rd_en_a), .rd_fire_i(rd_fire), .rd_last_o(rd_last_a),
    .frame_done_o(done_a)
  );

  reorder_bank_scheduler #(.MaxLineSize(512), .MaxLines(4096), .DoubleBuff(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .cfg_line_len_i(cfg_len), .cfg_num_lines_i(cfg_lines),
    .start_i(start), .abort_i(abort), .busy_o(busy_b), .cfg_err_o(err_b),
    .wr_bank_o(wr_bank_b), .wr_en_o(wr_en_b), .wr_fire_i(wr_fire), .wr_last_o(wr_last_b),
    .rd_bank_o(rd_bank_b), .rd_en_o(rd_en_b), .rd_fire_i(rd_fire), .rd_last_o(rd_last_b),
    .frame_done_o(done_b)
  );

  typedef struct {
    logic [LW-1:0] len;
    logic [NW-1:0] lines;
    logic          exp_err;
    logic          exp_busy;
  } cfg_vec_t;

  cfg_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_fire = 1'b0; rd_fire = 1'b0;
    cfg_len = '0; cfg_lines = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic start_frame(input int len, input int lines);
    cfg_len = LW'(len); cfg_lines = NW'(lines); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int wb, rb, last_rd_cyc, last_wr_cyc, done_cnt, done_cyc, bank_nz;

    vecs[0] = '{len: 10'd0,   lines: 13'd3,    exp_err: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{len: 10'd513, lines: 13'd3,    exp_err: 1'b1, exp_busy: 1'b0};
    vecs[2] = '{len: 10'd4,   lines: 13'd0,    exp_err: 1'b1, exp_busy: 1'b0};
    vecs[3] = '{len: 10'd4,   lines: 13'd4097, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[4] = '{len: 10'd512, lines: 13'd4096, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[5] = '{len: 10'd1,   lines: 13'd1,    exp_err: 1'b0, exp_busy: 1'b1};

    // ---------------- reset state ----------------
    do_reset();
    check("rst_busy", busy_a, 0);
    check("rst_wr_en", wr_en_a, 0);
    check("rst_rd_en", rd_en_a, 0);
    check("rst_cfg_err", err_a, 0);
    check("rst_done", done_a, 0);

    // ---------------- config table ----------------
    for (int i = 0; i < 6; i++) begin
      start_frame(int'(vecs[i].len), int'(vecs[i].lines));
      check($sformatf("cfg_err[%0d]", i), err_a, vecs[i].exp_err);
      check($sformatf("cfg_busy[%0d]", i), busy_a, vecs[i].exp_busy);
      step();
      check($sformatf("cfg_err_pulse[%0d]", i), err_a, 0);
      check($sformatf("cfg_busy_hold[%0d]", i), busy_a, vecs[i].exp_busy);
      abort = 1'b1; step(); abort = 1'b0;
      check($sformatf("cfg_abort_idle[%0d]", i), busy_a, 0);
    end

    // ---------------- reset mid-RUN ----------------
    do_reset();
    start_frame(4, 3);
    wr_fire = 1'b1;
    step(); step(); step();
    wr_fire = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_busy", busy_a, 0);
    check("mrst_wr_en", wr_en_a, 0);
    check("mrst_wr_last", wr_last_a, 0);
    check("mrst_rd_en", rd_en_a, 0);
    check("mrst_wr_bank", wr_bank_a, 0);
    start_frame(4, 3);
    check("mrst_fresh_wr_en", wr_en_a, 1);
    check("mrst_fresh_wr_last", wr_last_a, 0);
    check("mrst_fresh_rd_en", rd_en_a, 0);

    // ---------------- len 4, lines 3, always-ready reader ----------------
    do_reset();
    start_frame(4, 3);
    wb = 0; rb = 0; done_cnt = 0; done_cyc = -1; last_rd_cyc = -10; last_wr_cyc = -10;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (done_a) begin
        done_cnt++;
        done_cyc = cyc;
        check("main_done_busy", busy_a, 0);
      end
      wr_fire = wr_en_a;
      rd_fire = rd_en_a;
      if (wr_en_a) begin
        check($sformatf("main_wr_last[%0d]", wb), wr_last_a, (wb % 4) == 3);
        if (wb % 4 == 0) check($sformatf("main_wr_bank[%0d]", wb / 4), wr_bank_a, (wb / 4) % 2);
        wb++;
        last_wr_cyc = cyc;
      end
      if (rd_en_a) begin
        check($sformatf("main_rd_last[%0d]", rb), rd_last_a, (rb % 4) == 3);
        if (rb % 4 == 0) check($sformatf("main_rd_bank[%0d]", rb / 4), rd_bank_a, (rb / 4) % 2);
        rb++;
        last_rd_cyc = cyc;
      end
      step();
    end
    wr_fire = 1'b0; rd_fire = 1'b0;
    check("main_wr_beats", wb, 12);
    check("main_rd_beats", rb, 12);
    check("main_no_bubble", last_wr_cyc, 11);
    check("main_done_count", done_cnt, 1);
    check("main_done_cycle", done_cyc, last_rd_cyc + 1);

    // ---------------- reader stalled, len 2, lines 4 ----------------
    do_reset();
    start_frame(2, 4);
    wb = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      wr_fire = wr_en_a;
      if (wr_en_a) wb++;
      step();
    end
    wr_fire = 1'b0;
    check("stall_wr_beats", wb, 4);
    check("stall_wr_en", wr_en_a, 0);
    check("stall_rd_en", rd_en_a, 1);
    check("stall_rd_bank", rd_bank_a, 0);
    rd_fire = 1'b1;
    check("stall_rd_last0", rd_last_a, 0);
    step();
    check("stall_wr_en_draining", wr_en_a, 0);
    check("stall_rd_last1", rd_last_a, 1);
    step();
    rd_fire = 1'b0;
    check("stall_wr_reopen", wr_en_a, 1);
    check("stall_wr_bank", wr_bank_a, 0);
    check("stall_rd_bank_next", rd_bank_a, 1);
    check("stall_rd_en_next", rd_en_a, 1);
    abort = 1'b1; step(); abort = 1'b0;

    // ---------------- single bank, len 3, lines 2 ----------------
    do_reset();
    start_frame(3, 2);
    wb = 0; rb = 0; done_cnt = 0; bank_nz = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done_b) done_cnt++;
      if (wr_bank_b || rd_bank_b) bank_nz++;
      if (wb == 3) begin
        if (rb < 3) check($sformatf("sb_stall[%0d]", cyc), wr_en_b, 0);
        else        check("sb_resume", wr_en_b, 1);
      end
      wr_fire = wr_en_b;
      rd_fire = rd_en_b;
      if (wr_en_b) wb++;
      if (rd_en_b) rb++;
      step();
    end
    wr_fire = 1'b0; rd_fire = 1'b0;
    check("sb_banks_zero", bank_nz, 0);
    check("sb_wr_beats", wb, 6);
    check("sb_rd_beats", rb, 6);
    check("sb_done_count", done_cnt, 1);

    // ---------------- abort with same-cycle write, start ignored in RUN ----------------
    do_reset();
    start_frame(2, 3);
    check("ab_wr_en", wr_en_a, 1);
    wr_fire = 1'b1;
    cfg_len = 10'd1; cfg_lines = 13'd1; start = 1'b1;
    step();
    start = 1'b0;
    check("ab_start_ignored", wr_last_a, 1);
    step();
    check("ab_line2_bank", wr_bank_a, 1);
    check("ab_line2_wr_en", wr_en_a, 1);
    abort = 1'b1;
    step();
    abort = 1'b0; wr_fire = 1'b0;
    check("ab_busy", busy_a, 0);
    check("ab_wr_en_off", wr_en_a, 0);
    check("ab_rd_en_off", rd_en_a, 0);
    done_cnt = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (done_a) done_cnt++;
      step();
    end
    check("ab_no_done", done_cnt, 0);
    start_frame(2, 1);
    check("ab_new_busy", busy_a, 1);
    check("ab_new_wr_en", wr_en_a, 1);
    check("ab_new_wr_bank", wr_bank_a, 0);
    check("ab_new_wr_last", wr_last_a, 0);
    check("ab_new_rd_en", rd_en_a, 0);
    wr_fire = 1'b1;
    step();
    check("ab_new_wr_last1", wr_last_a, 1);
    step();
    wr_fire = 1'b0;
    check("ab_new_rd_en1", rd_en_a, 1);
    check("ab_new_wr_en_done", wr_en_a, 0);
    rd_fire = 1'b1;
    step();
    check("ab_new_rd_last", rd_last_a, 1);
    step();
    rd_fire = 1'b0;
    check("ab_new_done", done_a, 1);
    check("ab_new_idle", busy_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reorder_bank_scheduler
`default_nettype wire
